// File: rtl/ks_pkg.sv
// Shared definitions for the Kogge-Stone add/sub pipeline stage: op codes,
// default data width, flag vector layout and small op-decoding helpers.
package ks_pkg;

  localparam int KS_DATA_WIDTH = 32;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_ADDC = 2'd2;
  localparam logic [1:0] OP_SUBC = 2'd3;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_NEG   = 3;
  localparam int FLAG_COUNT = 4;

  // Op encoding: bit 0 selects subtract, bit 1 selects the chained carry-in.
  function automatic logic op_is_sub(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SUBC);
  endfunction

  function automatic logic op_uses_carry(input logic [1:0] op);
    return (op == OP_ADDC) || (op == OP_SUBC);
  endfunction

endpackage

// File: rtl/ks_flag_gen.sv
// Combinational flag derivation from the adder operand MSBs and the adder
// result; produces a packed flag vector laid out by the ks_pkg indices.
module ks_flag_gen
  import ks_pkg::*;
#(
  parameter int DATA_WIDTH = KS_DATA_WIDTH
) (
  input  logic                  a_msb,
  input  logic                  b_msb,
  input  logic [DATA_WIDTH-1:0] sum,
  input  logic                  ovf,
  output logic [FLAG_COUNT-1:0] flags
);

  // Carry-out is rebuilt from the MSB column alone: both MSBs set always
  // carry, exactly one set carries only when the sum MSB came out clear.
  always_comb begin
    flags             = '0;
    flags[FLAG_CARRY] = (a_msb & b_msb) | ((a_msb ^ b_msb) & ~sum[DATA_WIDTH-1]);
    flags[FLAG_OVF]   = ovf;
    flags[FLAG_ZERO]  = ~|sum;
    flags[FLAG_NEG]   = sum[DATA_WIDTH-1];
  end

endmodule

// File: rtl/ks_addsub_pipe_stage.sv
// Two-stage operand/result wrapper around an external Kogge-Stone adder core,
// supporting ADD/SUB/ADDC/SUBC with a carry chain and valid/ready on both sides.
module ks_addsub_pipe_stage
  import ks_pkg::*;
#(
  parameter int DATA_WIDTH   = KS_DATA_WIDTH,
  parameter int OUTPUT_WIDTH = DATA_WIDTH + 1
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  input  logic [1:0]              in_op,
  output logic [DATA_WIDTH-1:0]   add_a,
  output logic [DATA_WIDTH-1:0]   add_b,
  output logic                    add_cin,
  input  logic [OUTPUT_WIDTH-1:0] add_s,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_sum,
  output logic                    out_carry,
  output logic                    out_ovf,
  output logic                    out_zero,
  output logic                    out_neg
);

  logic                  s1_valid;
  logic                  s2_valid;
  logic [1:0]            s1_op;
  logic                  carry_q;
  logic                  s2_free;
  logic                  s1_adv;
  logic                  accept;
  logic [FLAG_COUNT-1:0] flags_d;
  logic [FLAG_COUNT-1:0] flags_q;

  // No skid buffer: in_ready depends combinationally on out_ready.
  always_comb begin
    s2_free  = ~s2_valid | out_ready;
    s1_adv   = s1_valid & s2_free;
    in_ready = ~s1_valid | s2_free;
    accept   = in_valid & in_ready;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      s1_valid <= 1'b0;
      add_a    <= '0;
      add_b    <= '0;
      s1_op    <= OP_ADD;
    end else begin
      s1_valid <= accept | (s1_valid & ~s1_adv);
      if (accept) begin
        add_a <= in_a;
        add_b <= op_is_sub(in_op) ? ~in_b : in_b;
        s1_op <= in_op;
      end
    end
  end

  // carry_q is written on the same edge the preceding op enters stage 2, so a
  // chained op now in stage 1 always sees its predecessor's carry.
  always_comb begin
    add_cin = op_uses_carry(s1_op) ? carry_q : op_is_sub(s1_op);
  end

  ks_flag_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_flag_gen (
    .a_msb (add_a[DATA_WIDTH-1]),
    .b_msb (add_b[DATA_WIDTH-1]),
    .sum   (add_s[DATA_WIDTH-1:0]),
    .ovf   (add_s[OUTPUT_WIDTH-1]),
    .flags (flags_d)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      s2_valid <= 1'b0;
      out_sum  <= '0;
      flags_q  <= '0;
      carry_q  <= 1'b0;
    end else begin
      s2_valid <= s1_adv | (s2_valid & ~out_ready);
      if (s1_adv) begin
        out_sum <= add_s[DATA_WIDTH-1:0];
        flags_q <= flags_d;
        carry_q <= flags_d[FLAG_CARRY];
      end
    end
  end

  always_comb begin
    out_valid = s2_valid;
    out_carry = flags_q[FLAG_CARRY];
    out_ovf   = flags_q[FLAG_OVF];
    out_zero  = flags_q[FLAG_ZERO];
    out_neg   = flags_q[FLAG_NEG];
  end

endmodule

// File: tb/tb_ks_addsub_pipe_stage.sv
// Scoreboard bench for ks_addsub_pipe_stage; a behavioural adder stands in for
// the Kogge-Stone core and a monitor checks results against queued expectations.
module tb_ks_addsub_pipe_stage;
  import ks_pkg::*;

  typedef struct packed {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic        neg;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_op;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [32:0] add_s;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_carry;
  logic        out_ovf;
  logic        out_zero;
  logic        out_neg;

  int   assertCount = 0;
  int   failCount   = 0;
  int   acceptCount = 0;
  exp_t expQ[$];

  always #5 CLK = ~CLK;

  ks_addsub_pipe_stage #(.DATA_WIDTH(32), .OUTPUT_WIDTH(33)) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_neg   (out_neg)
  );

  // Behavioural adder core: overflow is carry into bit 31 xor carry out of it.
  logic [32:0] fullSum;
  logic [31:0] lowSum;
  always_comb begin
    fullSum = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);
    lowSum  = {1'b0, add_a[30:0]} + {1'b0, add_b[30:0]} + 32'(add_cin);
    add_s   = {lowSum[31] ^ fullSum[32], fullSum[31:0]};
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Starts and ends at a falling edge; holds the request until accepted.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int waitCycles;
    waitCycles = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    #1;
    while (!in_ready && waitCycles < 50) begin
      @(negedge CLK);
      #1;
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      expQ.push_back(e);
      acceptCount++;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idleInput();
    in_valid = 1'b0;
    in_op    = OP_ADD;
    in_a     = '0;
    in_b     = '0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("drain_queue_size", 64'(expQ.size()), 64'd0);
  endtask

  // Monitor: pops on a transfer, and while stalled checks the held result.
  always begin
    @(negedge CLK);
    #2;
    if (RST_n && out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", 64'(out_valid), 64'd0);
      end else if (out_ready) begin
        checkOutput("result", 64'({out_sum, out_carry, out_ovf, out_zero, out_neg}), 64'(expQ[0]));
        void'(expQ.pop_front());
      end else begin
        checkOutput("stall_hold_sum", 64'(out_sum), 64'(expQ[0].sum));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST_n     = 1'b0;
    out_ready = 1'b1;
    idleInput();
    repeat (2) @(negedge CLK);

    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_result", 64'({out_sum, out_carry, out_ovf, out_zero, out_neg}), 64'd0);
    checkOutput("reset_adder_drive", 64'({add_a, add_b[30:0], add_cin}), 64'd0);

    #3 RST_n = 1'b1;
    @(negedge CLK);

    // Basic arithmetic, issued back to back.
    applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0});
    applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1});
    applyStimulus(OP_SUB, 32'd5, 32'd7, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1});
    applyStimulus(OP_SUB, 32'd7, 32'd5, '{32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0});

    // Dependent carry chains with no gap between ops.
    applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0});
    applyStimulus(OP_ADDC, 32'd0, 32'd0, '{32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(OP_SUB, 32'd0, 32'd1, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1});
    applyStimulus(OP_SUBC, 32'd0, 32'd0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1});
    idleInput();
    waitDrain();

    // Output stall: only two ops fit in the pipeline.
    @(negedge CLK);
    out_ready   = 1'b0;
    acceptCount = 0;
    applyStimulus(OP_ADD, 32'd10, 32'd20, '{32'd30, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(OP_ADD, 32'd3, 32'd4, '{32'd7, 1'b0, 1'b0, 1'b0, 1'b0});
    in_valid = 1'b1;
    in_op    = OP_ADD;
    in_a     = 32'd100;
    in_b     = 32'hFFFF_FF9C;
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      @(negedge CLK);
    end
    checkOutput("stall_accept_count", 64'(acceptCount), 64'd2);
    out_ready = 1'b1;
    applyStimulus(OP_ADD, 32'd100, 32'hFFFF_FF9C, '{32'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    idleInput();
    waitDrain();

    // Asynchronous reset with both stages occupied.
    @(negedge CLK);
    out_ready = 1'b0;
    applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0});
    applyStimulus(OP_ADD, 32'd1, 32'd1, '{32'd2, 1'b0, 1'b0, 1'b0, 1'b0});
    idleInput();
    checkOutput("pre_reset_full", 64'({out_valid, in_ready, dut.carry_q}), 64'b101);
    #3 RST_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("async_reset_carry_q", 64'(dut.carry_q), 64'd0);
    checkOutput("async_reset_result", 64'({out_sum, out_carry, out_ovf, out_zero, out_neg}), 64'd0);
    expQ.delete();
    @(negedge CLK);
    #3 RST_n = 1'b1;
    @(negedge CLK);
    out_ready = 1'b1;
    applyStimulus(OP_ADDC, 32'd0, 32'd0, '{32'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    idleInput();
    waitDrain();

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
